reg_targetio_mux: RTL

//  Parametrised successor to the fixed target-pin muxing in the capture top level.

---
 rtl/reg_targetio_mux.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/reg_targetio_mux.sv
// ============================================================================
// Module      : reg_targetio_mux
// Description : Register-controlled per-pin target I/O routing with a
//               power-up settle sequencer that holds every pin high-Z.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_targetio_mux #(
    parameter int         NUM_IO        = 8,
    parameter logic [5:0] ADDR_MODE     = 6'd40,
    parameter logic [5:0] ADDR_GPIO     = 6'd41,
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic [5:0]        reg_address,
    input  logic [15:0]       reg_bytecnt,
    input  logic [7:0]        reg_datai,
    output logic [7:0]        reg_datao,
    input  logic              reg_read,
    input  logic              reg_write,
    input  logic              reg_addrvalid,
    input  logic [5:0]        reg_hypaddress,
    output logic [15:0]       reg_hyplen,
    input  logic              targetpower_off,
    input  logic [NUM_IO-1:0] io_i,
    output logic [NUM_IO-1:0] io_o,
    output logic [NUM_IO-1:0] io_oe,
    input  logic [NUM_IO-1:0] alt_i,
    input  logic              uart_tx_i,
    output logic              uart_rx_o,
    output logic              io_highz_o
);

    localparam int             c_GPIO_BYTES = (NUM_IO + 7) / 8;
    localparam int             c_PAD_W      = c_GPIO_BYTES * 8;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_highz;

    logic [2:0]         r_mode [NUM_IO];
    logic [NUM_IO-1:0]  r_gpio_out;
    logic [NUM_IO-1:0]  r_sync1;
    logic [NUM_IO-1:0]  r_sync2;
    logic [NUM_IO-1:0]  r_io_o;
    logic [NUM_IO-1:0]  r_io_oe;
    logic               r_uart_rx;
    logic [7:0]         r_datao;

    logic               w_wr_mode;
    logic               w_wr_gpio;
    logic [NUM_IO-1:0]  w_gpio_sel;
    logic [NUM_IO-1:0]  w_gpio_din;
    logic [NUM_IO-1:0]  w_io_o_next;
    logic [NUM_IO-1:0]  w_io_oe_next;
    logic               w_rx_next;
    logic [c_PAD_W-1:0] w_sync_pad;
    logic [2:0]         w_mode_rd;
    logic [7:0]         w_gpio_rd;
    logic [7:0]         w_rd_data;

    // ---------------- power sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (r_state == ST_SETTLE) ? r_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OFF:    if (!targetpower_off) w_state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (targetpower_off)          w_state_next = ST_OFF;
                else if (r_cnt == c_CNT_LAST) w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: if (targetpower_off)  w_state_next = ST_OFF;
            default:                         w_state_next = ST_OFF;
        endcase
    end

    assign w_highz    = (r_state != ST_ACTIVE);
    assign io_highz_o = w_highz;

    // ---------------- register writes ----------------
    assign w_wr_mode = reg_write && reg_addrvalid && (reg_address == ADDR_MODE);
    assign w_wr_gpio = reg_write && reg_addrvalid && (reg_address == ADDR_GPIO);

    for (genvar k = 0; k < NUM_IO; k++) begin : g_gpio_bit
        assign w_gpio_sel[k] = w_wr_gpio && (reg_bytecnt == 16'(k / 8));
        assign w_gpio_din[k] = reg_datai[k % 8];
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_gpio_out <= '0;
            for (int k = 0; k < NUM_IO; k++) r_mode[k] <= '0;
        end else begin
            r_gpio_out <= (r_gpio_out & ~w_gpio_sel) | (w_gpio_din & w_gpio_sel);
            for (int k = 0; k < NUM_IO; k++) begin
                if (w_wr_mode && (reg_bytecnt == 16'(k))) r_mode[k] <= reg_datai[2:0];
            end
        end
    end

    // ---------------- pad routing ----------------
    always_comb begin
        w_io_o_next  = '0;
        w_io_oe_next = '0;
        w_rx_next    = 1'b1;
        for (int k = 0; k < NUM_IO; k++) begin
            case (r_mode[k])
                3'd1: begin w_io_oe_next[k] = 1'b1; w_io_o_next[k] = r_gpio_out[k]; end
                3'd2: begin w_io_oe_next[k] = 1'b1; w_io_o_next[k] = uart_tx_i;     end
                3'd3: w_rx_next = w_rx_next & r_sync2[k];
                3'd4: begin w_io_oe_next[k] = 1'b1; w_io_o_next[k] = alt_i[k];      end
                default: ;
            endcase
        end
        if (w_highz) begin
            w_io_o_next  = '0;
            w_io_oe_next = '0;
            w_rx_next    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_io_o    <= '0;
            r_io_oe   <= '0;
            r_uart_rx <= 1'b1;
        end else begin
            r_sync1   <= io_i;
            r_sync2   <= r_sync1;
            r_io_o    <= w_io_o_next;
            r_io_oe   <= w_io_oe_next;
            r_uart_rx <= w_rx_next;
        end
    end

    assign io_o      = r_io_o;
    assign io_oe     = r_io_oe;
    assign uart_rx_o = r_uart_rx;

    // ---------------- register reads ----------------
    assign w_sync_pad = c_PAD_W'(r_sync2);

    always_comb begin
        w_mode_rd = '0;
        w_gpio_rd = '0;
        w_rd_data = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (reg_bytecnt == 16'(k)) w_mode_rd = r_mode[k];
        end
        for (int b = 0; b < c_GPIO_BYTES; b++) begin
            if (reg_bytecnt == 16'(b)) w_gpio_rd = w_sync_pad[8*b +: 8];
        end
        if (reg_address == ADDR_MODE)      w_rd_data = {5'b0, w_mode_rd};
        else if (reg_address == ADDR_GPIO) w_rd_data = w_gpio_rd;
    end

    always_ff @(posedge clk) begin
        if (reset_i) r_datao <= '0;
        else         r_datao <= (reg_read && reg_addrvalid) ? w_rd_data : 8'h00;
    end

    assign reg_datao = r_datao;

    always_comb begin
        reg_hyplen = '0;
        if (reg_hypaddress == ADDR_MODE)      reg_hyplen = 16'(NUM_IO);
        else if (reg_hypaddress == ADDR_GPIO) reg_hyplen = 16'(c_GPIO_BYTES);
    end

endmodule

`default_nettype wire
